// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 24-bit combinational ALU: accepts ops, drives the ALU, captures C into AC.
// Optional macro ALU_SEQ_ILLEGAL_TRAP_EN traps opcodes 13-15 and adds the sticky illegal_op output.
module alu_op_sequencer #(
  parameter int DATA_W   = 24,
  parameter int OP_W     = 4,
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_oper,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_z,
  output logic [DATA_W-1:0] ac_out,
  output logic              z_out,
  output logic [CNT_W-1:0]  q_out,
  output logic              ovf,
  output logic              done
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic              illegal_op
`endif
);

  localparam logic [OP_W-1:0] OP_NOP     = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LOOPSUB = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ILL_LO  = OP_W'(13);

  typedef enum logic [1:0] {IDLE, EXEC, LOOP, DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   opr;
  logic [OP_W-1:0]     op_r;
  logic                loop_cap;
  logic                loop_lt;
  logic                loop_sub;

  assign alu_a = ac_out;
  assign alu_b = opr;

  // Exit test first: the iteration cap wins over the AC<OPR comparison.
  assign loop_cap = (q_out == CNT_W'(MAX_ITER));
  assign loop_lt  = (ac_out < opr);
  assign loop_sub = (state == LOOP) && !loop_cap && !loop_lt;

  always_comb begin
    alu_oper = OP_NOP;
    if (state == EXEC)
      alu_oper = op_r;
    else if (loop_sub)
      alu_oper = OP_SUB;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ac_out    <= '0;
      opr       <= '0;
      op_r      <= OP_NOP;
      q_out     <= '0;
      z_out     <= 1'b0;
      ovf       <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      illegal_op <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            opr       <= cmd_data;
            cmd_ready <= 1'b0;
            if (cmd_op == OP_LOOPSUB) begin
              q_out <= '0;
              ovf   <= 1'b0;
              state <= LOOP;
            end else if (cmd_op >= OP_ILL_LO) begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
              illegal_op <= 1'b1;
              done       <= 1'b1;
              state      <= DONE;
`else
              op_r  <= OP_NOP;
              state <= EXEC;
`endif
            end else begin
              op_r  <= cmd_op;
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (op_r != OP_NOP)
            ac_out <= alu_c;
          if (op_r == OP_SUB)
            z_out <= alu_z;
          done  <= 1'b1;
          state <= DONE;
        end
        LOOP: begin
          if (loop_cap) begin
            ovf   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (loop_lt) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            ac_out <= alu_c;
            z_out  <= alu_z;
            q_out  <= q_out + CNT_W'(1);
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
